// File: rtl/timer_periph.sv
// timer_periph: APB slave timer with a prescaled auto-reload up-counter, an update flag with
// level interrupt, and an optional PWM compare output.
//
// Build option: define TIMER_PWM_EN to include the CCR register and the PWM output; otherwise
// offset 0x14 reads 0 and pwm_out is tied low.
//
// Ports:
//   PCLK     - sole clock
//   PRESET   - asynchronous active-low reset
//   PADDR    - APB address, only bits [4:2] decoded
//   PWDATA   - APB write data (bits above the field width ignored)
//   PWRITE   - 1 = write, 0 = read
//   PENABLE  - APB access phase
//   PSEL     - slave select
//   PRDATA   - read data, driven only while PREADY is high, otherwise 0
//   PREADY   - registered, high for one cycle per transfer (one wait state)
//   irq      - UIF & IRQ_EN, level
//   pwm_out  - registered EN & (TCNT < CCR), or 0 without TIMER_PWM_EN
//
// Register map (word offsets):
//   0x00 TCR  [0] EN, [1] CLR (write-1 pulse, reads 0), [2] IRQ_EN
//   0x04 PSC  prescale, tick every PSC+1 enabled cycles
//   0x08 ARR  auto-reload limit
//   0x0C TCNT counter, read-only
//   0x10 TSR  [0] UIF, write 1 to clear
//   0x14 CCR  PWM compare (TIMER_PWM_EN only)
module timer_periph #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq,
    output logic        pwm_out
);

    // Register state
    logic             pready_q, pready_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0] arr_q, arr_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             uif_q, uif_d;

    // Decode
    logic       access;
    logic       wr_en;
    logic [2:0] idx;
    logic       wr_tcr, wr_psc, wr_arr, wr_tsr;
    logic       clr;
    logic       tick;
    logic       wrap;
    logic       update;
    logic [31:0] rdata;

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    assign access = PSEL & PENABLE;
    // Writes commit at the edge that ends the PREADY=1 cycle.
    assign wr_en  = access & pready_q & PWRITE;
    assign idx    = PADDR[4:2];
    assign wr_tcr = wr_en && (idx == 3'd0);
    assign wr_psc = wr_en && (idx == 3'd1);
    assign wr_arr = wr_en && (idx == 3'd2);
    assign wr_tsr = wr_en && (idx == 3'd4);

    assign clr    = wr_tcr & PWDATA[1];
    assign tick   = en_q & (psc_cnt_q == psc_q);
    // >= rather than == so a reduced ARR wraps on the next tick instead of running out.
    assign wrap   = (tcnt_q >= arr_q);
    // CLR suppresses any update that would coincide with it.
    assign update = tick & wrap & ~clr;

`ifdef TIMER_PWM_EN
    logic [CNT_W-1:0] ccr_q, ccr_d;
    logic             pwm_q, pwm_d;
    logic             wr_ccr;

    assign wr_ccr  = wr_en && (idx == 3'd5);
    assign ccr_d   = wr_ccr ? PWDATA[CNT_W-1:0] : ccr_q;
    assign pwm_d   = en_q & (tcnt_q < ccr_q);
    assign pwm_out = pwm_q;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            ccr_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            ccr_q <= ccr_d;
            pwm_q <= pwm_d;
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

    always_comb begin
        // Only the first sampled access cycle raises PREADY; it then drops for one cycle.
        pready_d  = access & ~pready_q;
        en_d      = wr_tcr ? PWDATA[0] : en_q;
        irq_en_d  = wr_tcr ? PWDATA[2] : irq_en_q;
        psc_d     = wr_psc ? PWDATA[PSC_W-1:0] : psc_q;
        arr_d     = wr_arr ? PWDATA[CNT_W-1:0] : arr_q;

        psc_cnt_d = psc_cnt_q;
        tcnt_d    = tcnt_q;
        if (clr) begin
            psc_cnt_d = '0;
            tcnt_d    = '0;
        end else if (tick) begin
            psc_cnt_d = '0;
            tcnt_d    = wrap ? '0 : tcnt_q + CNT_W'(1);
        end else if (en_q) begin
            psc_cnt_d = psc_cnt_q + PSC_W'(1);
        end

        // Set wins over a simultaneous write-1-to-clear.
        uif_d = uif_q;
        if (update) begin
            uif_d = 1'b1;
        end else if (wr_tsr && PWDATA[0]) begin
            uif_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            pready_q  <= 1'b0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            arr_q     <= '0;
            tcnt_q    <= '0;
            uif_q     <= 1'b0;
        end else begin
            pready_q  <= pready_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            arr_q     <= arr_d;
            tcnt_q    <= tcnt_d;
            uif_q     <= uif_d;
        end
    end

    // Read mux; fields are zero-extended, CLR always reads 0.
    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = {29'd0, irq_en_q, 1'b0, en_q};
            3'd1:    rdata = 32'(psc_q);
            3'd2:    rdata = 32'(arr_q);
            3'd3:    rdata = 32'(tcnt_q);
            3'd4:    rdata = {31'd0, uif_q};
`ifdef TIMER_PWM_EN
            3'd5:    rdata = 32'(ccr_q);
`endif
            default: rdata = '0;
        endcase
    end

    assign PREADY = pready_q;
    assign PRDATA = pready_q ? rdata : 32'd0;
    assign irq    = uif_q & irq_en_q;

endmodule

// File: tb/tb_timer_periph.sv
// Scoreboard bench for timer_periph: reads push their expected data, a negedge monitor pops and
// compares whenever the DUT completes a read. Timing-sensitive expectations assume each APB
// transfer from this bench occupies exactly four clock cycles.
module tb_timer_periph;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;
    logic        pwm_out;

    timer_periph #(
        .CNT_W(16),
        .PSC_W(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .irq    (irq),
        .pwm_out(pwm_out)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] TCR  = 32'h00;
    localparam logic [31:0] PSC  = 32'h04;
    localparam logic [31:0] ARR  = 32'h08;
    localparam logic [31:0] TCNT = 32'h0C;
    localparam logic [31:0] TSR  = 32'h10;
    localparam logic [31:0] CCR  = 32'h14;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every completed read is compared against the oldest expectation.
    always @(negedge PCLK) begin
        if (PRESET && PREADY && PSEL && PENABLE && !PWRITE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", PRDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, PRDATA, e.exp);
            end
        end
    end

    // Four-cycle transfer: setup, access, PREADY cycle, return to idle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (!PREADY && n < 16);
        check("pready_latency", 32'(n), 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("pready_one_cycle", {31'd0, PREADY}, 32'd0);
        check("prdata_idle_zero", PRDATA, 32'd0);
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        apb_xfer(1'b1, addr, data);
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        apb_xfer(1'b0, addr, 32'd0);
    endtask

    task automatic do_reset();
        PRESET = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // 1. Reset state
        check("reset_pready", {31'd0, PREADY}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_pwm", {31'd0, pwm_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            apb_read(32'(i * 4), 32'd0, $sformatf("reset_read_%0d", i));
        end

        // 2. PSC=3, ARR=4: TCNT advances once per 4-cycle read slot, wraps on the 5th tick.
        apb_write(PSC, 32'd3);
        apb_write(ARR, 32'd4);
        apb_write(TCR, 32'h5);
        for (int k = 0; k < 5; k++) begin
            apb_read(TCNT, 32'(k), $sformatf("t2_tcnt_%0d", k));
        end
        apb_read(TCNT, 32'd0, "t2_tcnt_wrap");
        apb_read(TSR, 32'd1, "t2_uif_set");
        check("t2_irq_high", {31'd0, irq}, 32'd1);
        apb_write(TSR, 32'd1);
        check("t2_irq_cleared", {31'd0, irq}, 32'd0);
        apb_read(TSR, 32'd0, "t2_uif_cleared");

        // 3. PSC=0, ARR=0: every enabled cycle is an update; set beats W1C.
        do_reset();
        apb_write(PSC, 32'd0);
        apb_write(ARR, 32'd0);
        apb_write(TCR, 32'h1);
        apb_read(TSR, 32'd1, "t3_uif_set");
        check("t3_irq_masked", {31'd0, irq}, 32'd0);
        apb_write(TSR, 32'd1);
        apb_read(TSR, 32'd1, "t3_set_wins");
        apb_read(TCNT, 32'd0, "t3_tcnt_zero");
        apb_write(TCR, 32'h0);
        apb_write(TSR, 32'd1);
        apb_read(TSR, 32'd0, "t3_uif_cleared_idle");

        // 4. Lower ARR below TCNT, then CLR on an update tick.
        do_reset();
        apb_write(PSC, 32'd3);
        apb_write(ARR, 32'd100);
        apb_write(TCR, 32'h1);
        for (int k = 0; k < 8; k++) begin
            apb_read(TCNT, 32'(k), $sformatf("t4_tcnt_%0d", k));
        end
        apb_write(ARR, 32'd5);
        apb_read(TCNT, 32'd9, "t4_tcnt_9");
        apb_read(TCNT, 32'd0, "t4_wrap_low_arr");
        apb_read(TSR, 32'd1, "t4_uif_low_arr");
        apb_write(TSR, 32'd1);
        apb_read(TCNT, 32'd3, "t4_tcnt_3");
        apb_read(TSR, 32'd0, "t4_uif_clear");
        apb_write(TCR, 32'h3);
        apb_read(TCNT, 32'd0, "t4_clr_tcnt");
        apb_read(TSR, 32'd0, "t4_clr_no_uif");
        apb_read(TCR, 32'h1, "t4_tcr_clr_reads0");

        // 5. Unmapped offsets, width truncation, reset mid-transfer.
        do_reset();
        apb_write(PSC, 32'hABCD_1234);
        apb_write(ARR, 32'h34);
        apb_write(TCR, 32'h4);
        apb_write(32'h1C, 32'hFFFF_FFFF);
        apb_write(32'h18, 32'hFFFF_FFFF);
        apb_read(32'h1C, 32'd0, "t5_unmapped_1c");
        apb_read(32'h18, 32'd0, "t5_unmapped_18");
        apb_read(PSC, 32'h1234, "t5_psc_trunc");
        apb_read(ARR, 32'h34, "t5_arr_kept");
        apb_read(TCR, 32'h4, "t5_tcr_kept");
        apb_read(TCNT, 32'd0, "t5_tcnt_kept");
        apb_read(CCR, 32'd0, "t5_ccr_zero");
        check("t5_irq_no_uif", {31'd0, irq}, 32'd0);
`ifndef TIMER_PWM_EN
        apb_write(CCR, 32'd7);
        apb_read(CCR, 32'd0, "t5_ccr_absent");
        check("t5_pwm_tied", {31'd0, pwm_out}, 32'd0);
`endif

        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = PSC;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("t5_pready_before_reset", {31'd0, PREADY}, 32'd1);
        PRESET = 1'b0;
        #1;
        check("t5_pready_reset", {31'd0, PREADY}, 32'd0);
        check("t5_prdata_reset", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b1;
        apb_read(PSC, 32'd0, "t5_psc_after_reset");
        apb_read(ARR, 32'd0, "t5_arr_after_reset");
        apb_read(TCR, 32'd0, "t5_tcr_after_reset");

`ifdef TIMER_PWM_EN
        // 6. PWM duty: high while TCNT < CCR, period ARR+1.
        begin
            int hi;
            int ccr_vals[3] = '{3, 0, 15};
            int exp_hi[3]   = '{6, 0, 20};
            do_reset();
            apb_write(PSC, 32'd0);
            apb_write(ARR, 32'd9);
            apb_write(TCR, 32'h1);
            for (int j = 0; j < 3; j++) begin
                apb_write(CCR, 32'(ccr_vals[j]));
                apb_read(CCR, 32'(ccr_vals[j]), $sformatf("t6_ccr_%0d", j));
                repeat (3) @(posedge PCLK);
                hi = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge PCLK);
                    if (pwm_out === 1'b1) hi++;
                end
                check($sformatf("t6_pwm_high_ccr%0d", ccr_vals[j]), 32'(hi), 32'(exp_hi[j]));
            end
        end
`endif

        repeat (4) @(posedge PCLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
